// File: rtl/instr_prefetch_pkg.sv
// Shared defines for the instruction prefetcher.
//   ILEN       : instruction word width (fixed at 32)
//   pf_state_e : memory-side fetch FSM encoding
package instr_prefetch_pkg;

    localparam int ILEN = 32;

    // IDLE : no request outstanding
    // REQ  : request outstanding, response will be queued
    // DROP : request outstanding but made stale by a redirect; response discarded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } pf_state_e;

endpackage

// File: rtl/instr_prefetch_sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous flush.
//   gclk, grst_n : clock, async active-low reset
//   flush        : empties the queue; overrides push and pop that cycle
//   push, wdata  : write side
//   pop, rdata   : read side; rdata is the head entry
//   empty, full  : occupancy flags
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             gclk,
    input  logic             grst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok, pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is reset so the head reads as zero while the block is in reset.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push_ok && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: fetches sequential instruction words into a small queue.
//   CLK, RES            : clock, async active-low reset
//   instr_req, pc_out   : memory request and its address (one outstanding)
//   instr_read          : returned word, qualified by instr_valid
//   fetch_valid/instr/pc: queue head toward the consumer
//   fetch_ready         : consumer takes the head
//   redirect/redirect_pc: flush the queue and refetch from a new target
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int             XLEN     = 32,
    parameter int             DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            RES,
    output logic            instr_req,
    output logic [XLEN-1:0] pc_out,
    input  logic [ILEN-1:0] instr_read,
    input  logic            instr_valid,
    output logic            fetch_valid,
    output logic [ILEN-1:0] fetch_instr,
    output logic [XLEN-1:0] fetch_pc,
    input  logic            fetch_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
);

    pf_state_e       state, state_nxt;
    // req_pc is the address being fetched (or next to fetch when IDLE).
    // tgt_pc holds the redirect target while a stale response drains in DROP,
    // so pc_out stays stable for the outstanding request.
    logic [XLEN-1:0] req_pc, req_pc_nxt;
    logic [XLEN-1:0] tgt_pc, tgt_pc_nxt;
    logic [XLEN-1:0] redir_pc;
    logic            q_push, q_pop, q_empty, q_full;
    logic [XLEN+ILEN-1:0] q_rdata;

    assign redir_pc = {redirect_pc[XLEN-1:2], 2'b00};

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state  <= IDLE;
            req_pc <= RESET_PC;
            tgt_pc <= RESET_PC;
        end else begin
            state  <= state_nxt;
            req_pc <= req_pc_nxt;
            tgt_pc <= tgt_pc_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_pc_nxt = req_pc;
        tgt_pc_nxt = tgt_pc;
        q_push     = 1'b0;
        case (state)
            IDLE: begin
                if (redirect)     req_pc_nxt = redir_pc;
                else if (!q_full) state_nxt  = REQ;
            end
            REQ: begin
                if (redirect) begin
                    if (instr_valid) begin
                        state_nxt  = IDLE;
                        req_pc_nxt = redir_pc;
                    end else begin
                        state_nxt  = DROP;
                        tgt_pc_nxt = redir_pc;
                    end
                end else if (instr_valid) begin
                    q_push     = 1'b1;
                    req_pc_nxt = req_pc + XLEN'(4);
                    state_nxt  = IDLE;
                end
            end
            DROP: begin
                if (redirect) tgt_pc_nxt = redir_pc;
                if (instr_valid) begin
                    state_nxt  = IDLE;
                    req_pc_nxt = redirect ? redir_pc : tgt_pc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign instr_req   = (state == REQ) || (state == DROP);
    assign pc_out      = req_pc;
    assign fetch_valid = !q_empty;
    assign q_pop       = fetch_valid && fetch_ready;
    assign fetch_pc    = q_rdata[XLEN+ILEN-1:ILEN];
    assign fetch_instr = q_rdata[ILEN-1:0];

    sync_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .gclk   (CLK),
        .grst_n (RES),
        .flush  (redirect),
        .push   (q_push),
        .wdata  ({req_pc, instr_read}),
        .pop    (q_pop),
        .rdata  (q_rdata),
        .empty  (q_empty),
        .full   (q_full)
    );

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch (XLEN=32, DEPTH=4, RESET_PC=0).
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_instr_prefetch;

    logic        CLK = 1'b0;
    logic        RES = 1'b0;
    logic        instr_req;
    logic [31:0] pc_out;
    logic [31:0] instr_read = '0;
    logic        instr_valid = 1'b0;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        fetch_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    int n_cmp = 0;
    int n_err = 0;

    instr_prefetch #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .CLK         (CLK),
        .RES         (RES),
        .instr_req   (instr_req),
        .pc_out      (pc_out),
        .instr_read  (instr_read),
        .instr_valid (instr_valid),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RES = 1'b0;
        instr_valid = 1'b0;
        redirect = 1'b0;
        fetch_ready = 1'b0;
        tick();
        RES = 1'b1;
    endtask

    // Word returned by the memory for a given address.
    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    initial begin
        // reset state
        tick();
        chk("rst_req", 32'(instr_req), 32'd0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_fv", 32'(fetch_valid), 32'd0);
        chk("rst_fi", fetch_instr, 32'h0);
        chk("rst_fp", fetch_pc, 32'h0);

        // S1: memory answers each request at once, consumer always ready
        RES = 1'b1;
        fetch_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("s1_req", 32'(instr_req), 32'd1);
            chk("s1_pc_out", pc_out, 32'(i * 4));
            instr_valid = 1'b1;
            instr_read  = word(32'(i * 4));
            tick();
            chk("s1_fv", 32'(fetch_valid), 32'd1);
            chk("s1_fetch_pc", fetch_pc, 32'(i * 4));
            chk("s1_fetch_instr", fetch_instr, word(32'(i * 4)));
            instr_valid = 1'b0;
            tick();
        end

        // S2: consumer stalled, queue fills to DEPTH then fetching stops
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s2_req", 32'(instr_req), 32'd1);
            chk("s2_pc_out", pc_out, 32'(i * 4));
            instr_valid = 1'b1;
            instr_read  = word(32'(i * 4));
            tick();
            instr_valid = 1'b0;
        end
        tick();
        chk("s2_full_req", 32'(instr_req), 32'd0);
        chk("s2_head", fetch_pc, 32'h0);
        tick();
        chk("s2_full_req2", 32'(instr_req), 32'd0);
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        chk("s2_pop_head", fetch_pc, 32'h4);
        chk("s2_pop_req", 32'(instr_req), 32'd0);
        tick();
        chk("s2_refill_req", 32'(instr_req), 32'd1);
        chk("s2_refill_pc", pc_out, 32'h10);

        // S3: redirect while request for 0x8 waits
        do_reset();
        fetch_ready = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            instr_valid = 1'b1;
            instr_read  = word(32'(i * 4));
            tick();
            instr_valid = 1'b0;
            tick();
        end
        chk("s3_wait_pc", pc_out, 32'h8);
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        chk("s3_drop_req", 32'(instr_req), 32'd1);
        chk("s3_drop_pc", pc_out, 32'h8);
        tick();
        instr_valid = 1'b1;
        instr_read  = 32'hDEAD_BEEF;
        tick();
        instr_valid = 1'b0;
        chk("s3_dropped_fv", 32'(fetch_valid), 32'd0);
        chk("s3_idle_req", 32'(instr_req), 32'd0);
        tick();
        chk("s3_new_pc", pc_out, 32'h100);
        instr_valid = 1'b1;
        instr_read  = word(32'h100);
        tick();
        instr_valid = 1'b0;
        chk("s3_new_fv", 32'(fetch_valid), 32'd1);
        chk("s3_new_fetch_pc", fetch_pc, 32'h100);

        // S4: redirect with push and pop at count=2
        do_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            instr_valid = 1'b1;
            instr_read  = word(32'(i * 4));
            tick();
            instr_valid = 1'b0;
        end
        tick();
        chk("s4_req_pc", pc_out, 32'h8);
        chk("s4_head", fetch_pc, 32'h0);
        instr_valid = 1'b1;
        instr_read  = word(32'h8);
        fetch_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h400;
        tick();
        instr_valid = 1'b0;
        redirect = 1'b0;
        chk("s4_flush_fv", 32'(fetch_valid), 32'd0);
        chk("s4_flush_req", 32'(instr_req), 32'd0);
        tick();
        chk("s4_pc", pc_out, 32'h400);
        chk("s4_empty_fv", 32'(fetch_valid), 32'd0);
        instr_valid = 1'b1;
        instr_read  = word(32'h400);
        tick();
        instr_valid = 1'b0;
        chk("s4_fetch_pc", fetch_pc, 32'h400);

        // S5: two redirects during DROP, last one wins
        do_reset();
        fetch_ready = 1'b1;
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        chk("s5_drop_pc", pc_out, 32'h0);
        redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        tick();
        instr_valid = 1'b1;
        instr_read  = 32'hDEAD_BEEF;
        tick();
        instr_valid = 1'b0;
        chk("s5_fv", 32'(fetch_valid), 32'd0);
        tick();
        chk("s5_pc", pc_out, 32'h300);
        instr_valid = 1'b1;
        instr_read  = word(32'h300);
        tick();
        instr_valid = 1'b0;
        chk("s5_fetch_pc", fetch_pc, 32'h300);

        // S6: reset pulse mid-request with count=3
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            instr_valid = 1'b1;
            instr_read  = word(32'(i * 4));
            tick();
            instr_valid = 1'b0;
        end
        tick();
        chk("s6_pre_pc", pc_out, 32'hC);
        RES = 1'b0;
        instr_valid = 1'b1;
        instr_read  = word(32'hC);
        #1;
        chk("s6_req", 32'(instr_req), 32'd0);
        chk("s6_pc", pc_out, 32'h0);
        chk("s6_fv", 32'(fetch_valid), 32'd0);
        chk("s6_fi", fetch_instr, 32'h0);
        chk("s6_fp", fetch_pc, 32'h0);
        tick();
        chk("s6_fv_hold", 32'(fetch_valid), 32'd0);
        RES = 1'b1;
        instr_valid = 1'b0;
        tick();
        chk("s6_restart_req", 32'(instr_req), 32'd1);
        chk("s6_restart_pc", pc_out, 32'h0);

        // S7: redirect in IDLE, address wrap past 2^32
        do_reset();
        fetch_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        chk("s7_idle_req", 32'(instr_req), 32'd0);
        tick();
        chk("s7_pc", pc_out, 32'hFFFF_FFFC);
        instr_valid = 1'b1;
        instr_read  = word(32'hFFFF_FFFC);
        tick();
        instr_valid = 1'b0;
        chk("s7_fetch_pc", fetch_pc, 32'hFFFF_FFFC);
        tick();
        chk("s7_wrap_pc", pc_out, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
